// File: rtl/sine_nco_pkg.sv
// Shared defaults for the sine NCO controller, sine_lut and their benches.
package sine_nco_pkg;
  localparam int ACC_WIDTH_DEFAULT   = 32;
  localparam int ADDR_WIDTH_DEFAULT  = 16;
  localparam int DATA_WIDTH_DEFAULT  = 16;
  localparam int LUT_LATENCY_DEFAULT = 1;
  localparam int CLK_DIV_DEFAULT     = 1;
endpackage

// File: rtl/nco_tick_div.sv
// Sample-tick divider: counts enabled clocks and flags the last one of each period.
module nco_tick_div #(
  parameter int CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count is frozen (not cleared) while disabled so a paused run resumes mid-period.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_en)   r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end

  assign o_tick = i_en & (r_cnt == LAST);
endmodule

// File: rtl/sine_nco_ctrl.sv
// Phase-accumulator NCO: drives sine_lut addresses on each tick and realigns
// the returned data into a valid-qualified sample stream.
module sine_nco_ctrl
  import sine_nco_pkg::*;
#(
  parameter int ACC_WIDTH   = ACC_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int LUT_LATENCY = LUT_LATENCY_DEFAULT,
  parameter int CLK_DIV     = CLK_DIV_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_phase_clr,
  input  logic [ACC_WIDTH-1:0]  i_ftw,
  input  logic                  i_ftw_valid,
  output logic                  o_ftw_ready,
  output logic [ADDR_WIDTH-1:0] o_lut_addr,
  input  logic [DATA_WIDTH-1:0] i_lut_data,
  output logic [DATA_WIDTH-1:0] o_sample,
  output logic                  o_sample_valid,
  output logic                  o_wrap
);
  logic                  w_tick_raw, w_tick, w_accept;
  logic [ACC_WIDTH-1:0]  w_inc;
  logic [ACC_WIDTH:0]    w_sum;

  logic [ACC_WIDTH-1:0]  r_acc, r_ftw_active, r_ftw_pend;
  logic                  r_pend_vld;
  logic [ADDR_WIDTH-1:0] r_lut_addr;
  logic                  r_wrap;
  logic [LUT_LATENCY:0]  r_vld_pipe;
  logic [DATA_WIDTH-1:0] r_sample;
  logic                  r_sample_valid;

  nco_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_clr  (i_phase_clr),
    .o_tick (w_tick_raw)
  );

  // A phase clear owns the accumulator that cycle, so it swallows any tick.
  assign w_tick   = w_tick_raw & ~i_phase_clr;
  assign w_accept = i_ftw_valid & ~r_pend_vld;
  assign w_inc    = r_pend_vld ? r_ftw_pend : r_ftw_active;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_inc};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc      <= '0;
      r_lut_addr <= '0;
      r_wrap     <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (i_phase_clr) begin
        r_acc <= '0;
      end else if (w_tick) begin
        r_acc      <= w_sum[ACC_WIDTH-1:0];
        r_lut_addr <= r_acc[ACC_WIDTH-1 -: ADDR_WIDTH];
        r_wrap     <= w_sum[ACC_WIDTH];
      end
    end
  end

  // Accept needs ready, i.e. no pending word, so it never collides with the
  // pending word being consumed by a tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ftw_active <= '0;
      r_ftw_pend   <= '0;
      r_pend_vld   <= 1'b0;
    end else begin
      if (w_tick && r_pend_vld) begin
        r_ftw_active <= r_ftw_pend;
        r_pend_vld   <= 1'b0;
      end
      if (w_accept) begin
        r_ftw_pend <= i_ftw;
        r_pend_vld <= 1'b1;
      end
    end
  end

  // Stage 0 lines up with the registered address; the last stage with LUT data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_pipe     <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_vld_pipe     <= {r_vld_pipe[LUT_LATENCY-1:0], w_tick};
      r_sample_valid <= r_vld_pipe[LUT_LATENCY];
      if (r_vld_pipe[LUT_LATENCY]) r_sample <= i_lut_data;
    end
  end

  assign o_ftw_ready    = ~r_pend_vld;
  assign o_lut_addr     = r_lut_addr;
  assign o_wrap         = r_wrap;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_sample_valid;
endmodule

// File: tb/tb_sine_nco_ctrl.sv
// Directed bench for sine_nco_ctrl: DUT A with CLK_DIV=1, DUT B with CLK_DIV=4,
// each fed by a one-cycle-latency LUT stub.
module tb_sine_nco_ctrl;
  import sine_nco_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        en_a, clr_a, fv_a, rdy_a, sv_a, wrap_a;
  logic [31:0] ftw_a;
  logic [15:0] addr_a, lut_a, smp_a;
  logic        en_b, clr_b, fv_b, rdy_b, sv_b, wrap_b;
  logic [31:0] ftw_b;
  logic [15:0] addr_b, lut_b, smp_b;

  int n_tests = 0;
  int n_fail  = 0;
  int bad_addr, bad_smp, bad_vld, wraps, wrap_k, stale;

  sine_nco_ctrl #(.CLK_DIV(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en_a), .i_phase_clr(clr_a),
    .i_ftw(ftw_a), .i_ftw_valid(fv_a), .o_ftw_ready(rdy_a),
    .o_lut_addr(addr_a), .i_lut_data(lut_a), .o_sample(smp_a),
    .o_sample_valid(sv_a), .o_wrap(wrap_a)
  );

  sine_nco_ctrl #(.CLK_DIV(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en_b), .i_phase_clr(clr_b),
    .i_ftw(ftw_b), .i_ftw_valid(fv_b), .o_ftw_ready(rdy_b),
    .o_lut_addr(addr_b), .i_lut_data(lut_b), .o_sample(smp_b),
    .o_sample_valid(sv_b), .o_wrap(wrap_b)
  );

  function automatic logic [15:0] lut_f(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    lut_a <= lut_f(addr_a);
    lut_b <= lut_f(addr_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    en_a = 0; clr_a = 0; fv_a = 0; ftw_a = '0;
    en_b = 0; clr_b = 0; fv_b = 0; ftw_b = '0;
    #1;
    chk("rst_addr", addr_a, 0);
    chk("rst_smp", smp_a, 0);
    chk("rst_vld", sv_a, 0);
    chk("rst_wrap", wrap_a, 0);
    chk("rst_rdy", rdy_a, 1);
    step();
    rst = 1'b0;

    // Increment by one, CLK_DIV=1
    ftw_a = 32'h0001_0000; fv_a = 1;
    step();
    fv_a = 0;
    chk("acc_rdy_drop", rdy_a, 0);
    en_a = 1;
    bad_addr = 0; bad_smp = 0; wraps = 0; wrap_k = 0;
    for (int k = 1; k <= 65540; k++) begin
      step();
      if (addr_a !== 16'((k - 1) & 16'hFFFF)) bad_addr++;
      if (wrap_a) begin wraps++; wrap_k = k; end
      if (k == 1) chk("rdy_back", rdy_a, 1);
      if (k == 2) chk("vld_not_yet", sv_a, 0);
      if (k == 3) begin
        chk("vld_first", sv_a, 1);
        chk("smp_first", smp_a, lut_f(16'h0000));
      end
      if (k >= 3 && (sv_a !== 1'b1 || smp_a !== lut_f(16'((k - 3) & 16'hFFFF)))) bad_smp++;
    end
    chk("inc1_addr_seq", bad_addr, 0);
    chk("inc1_smp_seq", bad_smp, 0);
    chk("inc1_wrap_cnt", wraps, 1);
    chk("inc1_wrap_at", wrap_k, 65536);

    // Tuning-word update mid-stream; address is 3 here
    ftw_a = 32'h0004_0000; fv_a = 1;
    step();
    chk("upd_addr0", addr_a, 16'd4);
    chk("upd_rdy_drop", rdy_a, 0);
    ftw_a = 32'h0007_0000;
    step();
    chk("upd_addr1", addr_a, 16'd5);
    chk("upd_rdy_back", rdy_a, 1);
    fv_a = 0;
    step();
    chk("upd_step4_a", addr_a, 16'd9);
    step();
    chk("upd_step4_b", addr_a, 16'd13);

    // Half-period step, preceded by a phase clear
    clr_a = 1; ftw_a = 32'h8000_0000; fv_a = 1;
    step();
    chk("clr_addr_hold", addr_a, 16'd13);
    chk("clr_wrap0", wrap_a, 0);
    clr_a = 0; fv_a = 0;
    step();
    chk("half_a0", addr_a, 16'h0000);
    step();
    chk("half_a1", addr_a, 16'h8000);
    chk("half_w1", wrap_a, 1);
    step();
    chk("half_a2", addr_a, 16'h0000);
    chk("half_w2", wrap_a, 0);
    step();
    chk("half_a3", addr_a, 16'h8000);
    chk("half_w3", wrap_a, 1);
    step();
    chk("half_a4", addr_a, 16'h0000);

    // Phase clear on a tick that would carry
    clr_a = 1; ftw_a = 32'h1234_0000; fv_a = 1;
    step();
    chk("pclr_addr", addr_a, 16'h0000);
    chk("pclr_nowrap", wrap_a, 0);
    clr_a = 0; fv_a = 0;
    step();
    chk("pclr_a0", addr_a, 16'h0000);
    step();
    chk("pclr_a1", addr_a, 16'h1234);
    clr_a = 1;
    step();
    chk("pclr2_hold", addr_a, 16'h1234);
    chk("pclr2_nowrap", wrap_a, 0);
    clr_a = 0;
    step();
    chk("pclr2_zero", addr_a, 16'h0000);
    step();
    chk("pclr2_ftw_kept", addr_a, 16'h1234);

    // Mid-pipeline reset
    rst = 1'b1;
    #1;
    chk("mrst_addr", addr_a, 0);
    chk("mrst_smp", smp_a, 0);
    chk("mrst_vld", sv_a, 0);
    chk("mrst_rdy", rdy_a, 1);
    en_a = 0;
    step();
    rst = 1'b0;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (sv_a !== 1'b0) stale++;
    end
    chk("mrst_no_stale", stale, 0);

    // Divider and enable, CLK_DIV=4
    ftw_b = 32'h0001_0000; fv_b = 1;
    step();
    fv_b = 0;
    chk("div_rdy_drop", rdy_b, 0);
    en_b = 1;
    bad_addr = 0; bad_vld = 0;
    for (int s = 1; s <= 25; s++) begin
      logic [15:0] ea;
      logic        ev;
      step();
      ea = (s < 8) ? 16'd0 : (s < 12) ? 16'd1 : (s < 22) ? 16'd2 : 16'd3;
      ev = (s == 6) || (s == 10) || (s == 14) || (s == 24);
      if (addr_b !== ea) bad_addr++;
      if (sv_b !== ev) bad_vld++;
      if (s == 3)  chk("div_rdy_wait", rdy_b, 0);
      if (s == 4)  chk("div_rdy_back", rdy_b, 1);
      if (s == 6)  chk("div_smp0", smp_b, lut_f(16'd0));
      if (s == 10) chk("div_smp1", smp_b, lut_f(16'd1));
      if (s == 14) chk("div_smp2_inflight", smp_b, lut_f(16'd2));
      if (s == 22) chk("div_resume_addr", addr_b, 16'd3);
      if (s == 24) chk("div_smp3", smp_b, lut_f(16'd3));
      if (s == 13) en_b = 0;
      if (s == 19) en_b = 1;
    end
    chk("div_addr_seq", bad_addr, 0);
    chk("div_vld_seq", bad_vld, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
